inlet_pump_sequencer: RTL

Digital controller for the on-chip 3-valve peristaltic pump that drives solution into an inlet of a serpentine channel chain. It also drives the inlet isolation valve. A host issues a stroke-count request. The block runs the six-phase valve pattern for that many strokes, then waits a transit delay so the last slug can reach the chain outlet. It reports completion over a valid/ready handshake.

---
 rtl/mfda_pump_pkg.sv | 35 +++
 rtl/inlet_pump_sequencer_if.sv | 24 ++
 rtl/inlet_pump_sequencer_phase_gen.sv | 67 ++++++
 rtl/inlet_pump_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mfda_pump_pkg.sv
// Shared types and constants for the inlet peristaltic pump sequencer.
// Valve words are {upstream, middle, downstream}; a 1 bit means that valve is closed.
package mfda_pump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PUMP,
    ST_TRANSIT,
    ST_REPORT
  } state_e;

  localparam logic [2:0] VALVES_CLOSED = 3'b111;
  localparam int         PHASES        = 6;

  // Entry 0 is P0; forward strokes walk upward, reverse strokes walk downward.
  localparam logic [PHASES-1:0][2:0] PHASE_PATTERN = {
    3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
  };

  function automatic logic [2:0] phase_valves(input logic [2:0] step, input logic dir);
    logic [2:0] idx;
    idx = dir ? (3'(PHASES - 1) - step) : step;
    return PHASE_PATTERN[idx];
  endfunction

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/inlet_pump_sequencer_if.sv
// Host-side request and completion handshakes of the inlet pump sequencer.
// The host is the master; the sequencer is the slave.
interface inlet_pump_sequencer_if #(
  parameter int STROKE_W = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [STROKE_W-1:0] req_strokes;
  logic                req_dir;
  logic                done_valid;
  logic                done_ready;
  logic [STROKE_W-1:0] done_strokes;
  logic                done_aborted;

  modport master (
    output req_valid, req_strokes, req_dir, done_ready,
    input  req_ready, done_valid, done_strokes, done_aborted
  );

  modport slave (
    input  req_valid, req_strokes, req_dir, done_ready,
    output req_ready, done_valid, done_strokes, done_aborted
  );
endinterface

// File: rtl/inlet_pump_sequencer_phase_gen.sv
// Six-phase valve pattern generator: holds each phase STEP_CYCLES cycles and
// flags the last cycle of every phase and of every stroke.
module pump_phase_gen
  import mfda_pump_pkg::*;
#(
  parameter int STEP_CYCLES = 1000,
  parameter int TIMER_W     = $clog2(STEP_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       dir_i,
  output logic [2:0] valve_ctl_o,
  output logic       phase_end_o,
  output logic       stroke_end_o
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         step_q, step_d, step_nxt;
  logic [2:0]         valve_q, valve_d;
  logic               active_q, active_d;

  // enable_i reflects the state of the next cycle, so valve_q lines up with PUMP exactly.
  assign phase_end_o  = active_q && (timer_q == TIMER_W'(STEP_CYCLES - 1));
  assign stroke_end_o = phase_end_o && (step_q == 3'(PHASES - 1));
  assign step_nxt     = (step_q == 3'(PHASES - 1)) ? 3'd0 : step_q + 3'd1;
  assign valve_ctl_o  = valve_q;

  always_comb begin
    timer_d  = timer_q;
    step_d   = step_q;
    valve_d  = valve_q;
    active_d = active_q;
    if (!enable_i) begin
      active_d = 1'b0;
      timer_d  = '0;
      step_d   = '0;
      valve_d  = VALVES_CLOSED;
    end else if (!active_q) begin
      active_d = 1'b1;
      timer_d  = '0;
      step_d   = '0;
      valve_d  = phase_valves(3'd0, dir_i);
    end else if (phase_end_o) begin
      timer_d = '0;
      step_d  = step_nxt;
      valve_d = phase_valves(step_nxt, dir_i);
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      step_q   <= '0;
      valve_q  <= VALVES_CLOSED;
      active_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      step_q   <= step_d;
      valve_q  <= valve_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/inlet_pump_sequencer.sv
// Inlet pump sequencer: accepts a stroke request, primes the inlet, pumps,
// waits for the last slug to transit the channel chain, then reports.
module inlet_pump_sequencer
  import mfda_pump_pkg::*;
#(
  parameter int STEP_CYCLES    = 1000,
  parameter int SETTLE_CYCLES  = 200,
  parameter int TRANSIT_CYCLES = 50000,
  parameter int STROKE_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  inlet_pump_sequencer_if.slave        bus,
  input  logic                         abort_i,
  output logic [2:0]                   valve_ctl_o,
  output logic                         inlet_open_o,
  output logic                         busy_o,
  output logic                         stroke_pulse_o
);

  localparam int TIMER_W = timer_width(STEP_CYCLES, SETTLE_CYCLES, TRANSIT_CYCLES);
  localparam logic [STROKE_W-1:0] COUNT_MAX = {STROKE_W{1'b1}};

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [STROKE_W-1:0] target_q, target_d;
  logic [STROKE_W-1:0] count_q, count_d, count_inc;
  logic                dir_q, dir_d;
  logic                abort_pend_q, abort_pend_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                inlet_open_q, inlet_open_d;
  logic                stroke_pulse_q, stroke_pulse_d;
  logic                done_valid_q, done_valid_d;
  logic [STROKE_W-1:0] done_strokes_q, done_strokes_d;
  logic                done_aborted_q, done_aborted_d;
  logic                finish, finish_aborted;
  logic                pump_en, phase_end, stroke_end;

  assign pump_en = (state_d == ST_PUMP);

  pump_phase_gen #(
    .STEP_CYCLES (STEP_CYCLES),
    .TIMER_W     (TIMER_W)
  ) u_phase_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (pump_en),
    .dir_i        (dir_q),
    .valve_ctl_o  (valve_ctl_o),
    .phase_end_o  (phase_end),
    .stroke_end_o (stroke_end)
  );

  assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + STROKE_W'(1);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + TIMER_W'(1);
    target_d       = target_q;
    count_d        = count_q;
    dir_d          = dir_q;
    abort_pend_d   = abort_pend_q;
    req_ready_d    = req_ready_q;
    busy_d         = busy_q;
    inlet_open_d   = inlet_open_q;
    stroke_pulse_d = 1'b0;
    done_valid_d   = done_valid_q;
    done_strokes_d = done_strokes_q;
    done_aborted_d = done_aborted_q;
    finish         = 1'b0;
    finish_aborted = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          target_d     = bus.req_strokes;
          dir_d        = bus.req_dir;
          count_d      = '0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          req_ready_d  = 1'b0;
          if (bus.req_strokes == '0) begin
            finish = 1'b1;
          end else begin
            state_d      = ST_PRIME;
            inlet_open_d = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        if (abort_i) begin
          finish         = 1'b1;
          finish_aborted = 1'b1;
        end else if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_PUMP;
        end
      end
      ST_PUMP: begin
        // An abort only takes effect once the phase in flight has finished.
        if (phase_end) begin
          abort_pend_d = 1'b0;
          if (stroke_end) begin
            count_d        = count_inc;
            stroke_pulse_d = 1'b1;
          end
          if (abort_i || abort_pend_q) begin
            finish         = 1'b1;
            finish_aborted = 1'b1;
          end else if (stroke_end && (count_inc == target_q)) begin
            state_d      = ST_TRANSIT;
            inlet_open_d = 1'b0;
          end
        end else if (abort_i) begin
          abort_pend_d = 1'b1;
        end
      end
      ST_TRANSIT: begin
        if (abort_i) begin
          finish         = 1'b1;
          finish_aborted = 1'b1;
        end else if (timer_q == TIMER_W'(TRANSIT_CYCLES - 1)) begin
          finish = 1'b1;
        end
      end
      ST_REPORT: begin
        if (bus.done_ready) begin
          state_d      = ST_IDLE;
          done_valid_d = 1'b0;
          busy_d       = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d        = ST_REPORT;
      inlet_open_d   = 1'b0;
      done_valid_d   = 1'b1;
      done_strokes_d = count_d;
      done_aborted_d = finish_aborted;
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      target_q       <= '0;
      count_q        <= '0;
      dir_q          <= 1'b0;
      abort_pend_q   <= 1'b0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      inlet_open_q   <= 1'b0;
      stroke_pulse_q <= 1'b0;
      done_valid_q   <= 1'b0;
      done_strokes_q <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      target_q       <= target_d;
      count_q        <= count_d;
      dir_q          <= dir_d;
      abort_pend_q   <= abort_pend_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      inlet_open_q   <= inlet_open_d;
      stroke_pulse_q <= stroke_pulse_d;
      done_valid_q   <= done_valid_d;
      done_strokes_q <= done_strokes_d;
      done_aborted_q <= done_aborted_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_strokes = done_strokes_q;
  assign bus.done_aborted = done_aborted_q;
  assign inlet_open_o     = inlet_open_q;
  assign busy_o           = busy_q;
  assign stroke_pulse_o   = stroke_pulse_q;

endmodule
